uart_rx_os16: RTL and testbench

Oversampling UART receiver. It recovers 8N1 frames from an asynchronous serial line using 16x oversampling with mid-bit sampling, and presents each byte through a valid/ready holding register. It sits in the board top between the PMOD RX pin and the byte consumer (display register or FIFO), running directly on the 100 MHz system clock rather than a derived baud clock. Framing errors and overruns are flagged.

---
 rtl/uart_rx_os16.sv | 139 +++++++++++++
 tb/tb_uart_rx_os16.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 16x oversampling 8N1 UART receiver with a valid/ready byte holding
// register, framing-error pulse and sticky overrun flag.
`default_nettype none

module uart_rx_os16 #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600,
  parameter int DIV      = CLK_FREQ / (BAUD * 16)
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_in,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TICK_MAX = CW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  logic          rx_meta_q, rxs_q;
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          tick;
  state_t        state_q;
  logic [3:0]    os_cnt_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic [7:0]    rx_data_q;
  logic          rx_valid_q, frame_err_q, overrun_q;

  assign tick      = (div_cnt_q == TICK_MAX);
  assign div_cnt_d = tick ? '0 : div_cnt_q + CW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      div_cnt_q <= '0;
    end else begin
      rx_meta_q <= rx_in;
      rxs_q     <= rx_meta_q;
      div_cnt_q <= div_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      os_cnt_q    <= 4'd0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
        overrun_q  <= 1'b0;
      end
      if (tick) begin
        case (state_q)
          S_IDLE: begin
            if (!rxs_q) begin
              state_q  <= S_START;
              os_cnt_q <= 4'd0;
            end
          end
          S_START: begin
            if (os_cnt_q == 4'd7) begin
              if (rxs_q) begin
                state_q <= S_IDLE;
              end else begin
                os_cnt_q  <= 4'd0;
                bit_cnt_q <= 3'd0;
                state_q   <= S_DATA;
              end
            end else begin
              os_cnt_q <= os_cnt_q + 4'd1;
            end
          end
          S_DATA: begin
            if (os_cnt_q == 4'd15) begin
              shift_q   <= {rxs_q, shift_q[7:1]};
              os_cnt_q  <= 4'd0;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) state_q <= S_STOP;
            end else begin
              os_cnt_q <= os_cnt_q + 4'd1;
            end
          end
          S_STOP: begin
            if (os_cnt_q == 4'd15) begin
              os_cnt_q <= 4'd0;
              if (rxs_q) begin
                // A same-edge handshake frees the holding register for the new byte.
                if (!rx_valid_q || rx_ready) begin
                  rx_data_q  <= shift_q;
                  rx_valid_q <= 1'b1;
                end else begin
                  overrun_q <= 1'b1;
                end
                state_q <= S_IDLE;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= S_BREAK;
              end
            end else begin
              os_cnt_q <= os_cnt_q + 4'd1;
            end
          end
          S_BREAK: begin
            if (rxs_q) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_os16.sv
// tb_uart_rx_os16: scenario tasks driving serial frames, expected bytes kept in a queue.
`default_nettype none

module tb_uart_rx_os16;

  localparam int BIT = 160;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_in = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];

  int   ferr_cnt = 0;
  int   vrise_cnt = 0;
  logic valid_prev = 1'b0;

  uart_rx_os16 #(.CLK_FREQ(1_600_000), .BAUD(10_000)) dut (
    .clk(clk), .reset_n(reset_n), .rx_in(rx_in), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) ferr_cnt = ferr_cnt + 1;
    if (rx_valid && !valid_prev) vrise_cnt = vrise_cnt + 1;
    valid_prev = rx_valid;
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
    rx_in = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx_in = stop_lvl;
    repeat (BIT) @(negedge clk);
    rx_in = 1'b1;
  endtask

  task automatic wait_valid(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (rx_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic pulse_ready;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({rx_data, rx_valid, frame_err, overrun} !== 11'h000) begin
      tests_failed++;
      $display("FAIL reset_outputs: got data=%h valid=%b ferr=%b ovr=%b, want all 0",
               rx_data, rx_valid, frame_err, overrun);
    end
    reset_n = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic test_basic;
    bit seen;
    logic [7:0] e;
    rx_ready = 1'b0;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_valid(seen);
    e = exp_q.pop_front();
    tests_run++;
    if (!seen || rx_data !== e) begin
      tests_failed++;
      $display("FAIL basic_data: got valid=%b data=%h, want valid=1 data=%h", seen, rx_data, e);
    end
    tests_run++;
    if (overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_overrun: got %b, want 0", overrun);
    end
    pulse_ready();
    tests_run++;
    if (rx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_handshake: got valid=%b, want 0", rx_valid);
    end
  endtask

  task automatic test_glitch;
    int f0, v0;
    f0 = ferr_cnt; v0 = vrise_cnt;
    rx_in = 1'b0;
    repeat (40) @(negedge clk);
    rx_in = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    tests_run++;
    if (vrise_cnt != v0 || ferr_cnt != f0 || overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch: got valid_pulses=%0d ferr=%0d ovr=%b, want 0 0 0",
               vrise_cnt - v0, ferr_cnt - f0, overrun);
    end
  endtask

  task automatic test_framing;
    int f0, v0;
    bit seen;
    logic [7:0] e;
    f0 = ferr_cnt; v0 = vrise_cnt;
    rx_ready = 1'b0;
    send_frame(8'h3C, 1'b0);
    rx_in = 1'b0;
    repeat (3 * BIT) @(negedge clk);
    rx_in = 1'b1;
    repeat (BIT) @(negedge clk);
    tests_run++;
    if (ferr_cnt - f0 != 1) begin
      tests_failed++;
      $display("FAIL frame_err_pulse: got %0d high cycles, want 1", ferr_cnt - f0);
    end
    tests_run++;
    if (vrise_cnt != v0 || rx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL frame_err_novalid: got valid_pulses=%0d valid=%b, want 0 0",
               vrise_cnt - v0, rx_valid);
    end
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    wait_valid(seen);
    e = exp_q.pop_front();
    tests_run++;
    if (!seen || rx_data !== e) begin
      tests_failed++;
      $display("FAIL after_break_data: got valid=%b data=%h, want valid=1 data=%h", seen, rx_data, e);
    end
    pulse_ready();
  endtask

  task automatic test_overrun;
    bit seen;
    logic [7:0] e;
    rx_ready = 1'b0;
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    wait_valid(seen);
    e = exp_q.pop_front();
    tests_run++;
    if (!seen || rx_data !== e) begin
      tests_failed++;
      $display("FAIL overrun_data: got valid=%b data=%h, want valid=1 data=%h", seen, rx_data, e);
    end
    tests_run++;
    if (overrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_set: got %b, want 1", overrun);
    end
    pulse_ready();
    tests_run++;
    if (rx_valid !== 1'b0 || overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL overrun_clear: got valid=%b ovr=%b, want 0 0", rx_valid, overrun);
    end
  endtask

  task automatic test_reset_midframe;
    bit seen;
    logic [7:0] e;
    logic [7:0] b;
    rx_ready = 1'b0;
    // Leave an unconsumed byte so the reset has something to clear.
    send_frame(8'h77, 1'b1);
    b = 8'hC3;
    rx_in = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx_in = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx_in = b[3];
    repeat (BIT / 2) @(negedge clk);
    tests_run++;
    if (rx_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset_valid: got %b, want 1", rx_valid);
    end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({rx_data, rx_valid, frame_err, overrun} !== 11'h000) begin
      tests_failed++;
      $display("FAIL midframe_reset: got data=%h valid=%b ferr=%b ovr=%b, want all 0",
               rx_data, rx_valid, frame_err, overrun);
    end
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (BIT) @(negedge clk);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    wait_valid(seen);
    e = exp_q.pop_front();
    tests_run++;
    if (!seen || rx_data !== e) begin
      tests_failed++;
      $display("FAIL post_reset_data: got valid=%b data=%h, want valid=1 data=%h", seen, rx_data, e);
    end
    pulse_ready();
  endtask

  task automatic test_back_to_back;
    int f0, v0;
    f0 = ferr_cnt; v0 = vrise_cnt;
    rx_ready = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h81);
    fork
      begin
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h81, 1'b1);
      end
      begin
        for (int k = 0; k < 3; k++) begin
          bit seen;
          logic [7:0] e;
          wait_valid(seen);
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          tests_run++;
          if (!seen || rx_data !== e) begin
            tests_failed++;
            $display("FAIL b2b_data[%0d]: got valid=%b data=%h, want valid=1 data=%h",
                     k, seen, rx_data, e);
          end
          @(negedge clk);
          tests_run++;
          if (rx_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_pulse[%0d]: got valid=%b one clk later, want 0", k, rx_valid);
          end
        end
      end
    join
    repeat (BIT) @(negedge clk);
    rx_ready = 1'b0;
    tests_run++;
    if (vrise_cnt - v0 != 3 || ferr_cnt != f0 || overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_summary: got pulses=%0d ferr=%0d ovr=%b, want 3 0 0",
               vrise_cnt - v0, ferr_cnt - f0, overrun);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_overrun();
    test_reset_midframe();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
